// File: rtl/bias_accumulator.sv
// -----------------------------------------------------------------------------
// bias_accumulator
//
// Sums a window of NUM_TERMS signed partial products coming from the MAC array.
// The per-channel bias is added once per window, captured together with the
// first term. The finished sum is narrowed to BIAS_WIDTH and held on a
// valid/ready output until the downstream quantization stage takes it. While
// a result is held, the input side is stalled, so the MAC stream is decoupled
// from downstream back-pressure.
//
// Configuration macro:
//   BIAS_ACC_SAT_EN  defined   -> the narrowed result saturates to the signed
//                                 BIAS_WIDTH range
//                    undefined -> the narrowed result keeps the low BIAS_WIDTH
//                                 bits (two's-complement wrap)
//   The macro changes only the narrowing. Timing and handshake are identical
//   in both builds.
//
// Widths BIAS_WIDTH / DATA_WIDTH come from the shared parameters header. The
// fallbacks below apply only when that header has not been seen.
//
// Ports:
//   clk        in   1           sole clock, rising edge
//   rst_n      in   1           synchronous active-low reset
//   in_valid   in   1           partial product present
//   in_ready   out  1           block accepts a partial product this cycle
//   in_psum    in   BIAS_WIDTH  signed partial product
//   bias       in   BIAS_WIDTH  signed bias, used with first term of a window
//   out_valid  out  1           result present
//   out_ready  in   1           downstream takes the result
//   out_data   out  BIAS_WIDTH  signed window result
// -----------------------------------------------------------------------------
`ifndef BIAS_WIDTH
`define BIAS_WIDTH 20
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module bias_accumulator #(
    parameter int NUM_TERMS = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`BIAS_WIDTH-1:0] in_psum,
    input  logic [`BIAS_WIDTH-1:0] bias,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`BIAS_WIDTH-1:0] out_data
);

    localparam int BW    = `BIAS_WIDTH;
    // Guard bits make the sum of bias plus NUM_TERMS terms overflow-free.
    localparam int ACC_W = BW + $clog2(NUM_TERMS + 1);
    localparam int CNT_W = (NUM_TERMS > 2) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BW-1:0]      out_data_reg, out_data_next;

    logic [ACC_W-1:0]   psum_ext;
    logic [ACC_W-1:0]   bias_ext;
    logic [ACC_W-1:0]   base;
    logic [ACC_W-1:0]   sum;
    logic [BW-1:0]      fit_sum;

    // Narrow the full-width sum to the output width.
    function automatic logic [BW-1:0] fit(input logic [ACC_W-1:0] value);
        logic [BW-1:0] result;
`ifdef BIAS_ACC_SAT_EN
        // The value fits only if every bit above the output sign bit
        // matches the top bit. Otherwise clamp towards the sign.
        if (value[ACC_W-1:BW-1] != {(ACC_W-BW+1){value[ACC_W-1]}}) begin
            if (value[ACC_W-1]) begin
                result = {1'b1, {(BW-1){1'b0}}};
            end else begin
                result = {1'b0, {(BW-1){1'b1}}};
            end
        end else begin
            result = value[BW-1:0];
        end
`else
        result = value[BW-1:0];
`endif
        return result;
    endfunction

    // Datapath: the first term of a window starts from the bias instead of
    // the running sum, so no separate clear cycle is needed.
    always_comb begin
        psum_ext = {{(ACC_W-BW){in_psum[BW-1]}}, in_psum};
        bias_ext = {{(ACC_W-BW){bias[BW-1]}}, bias};
        base     = (cnt_reg == '0) ? bias_ext : acc_reg;
        sum      = base + psum_ext;
        fit_sum  = fit(sum);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ACCUM;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            out_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            out_data_reg <= out_data_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        out_data_next = out_data_reg;

        case (state_reg)
            ACCUM: begin
                if (in_valid) begin
                    acc_next = sum;
                    if (cnt_reg == LAST_CNT) begin
                        cnt_next      = '0;
                        out_data_next = fit_sum;
                        state_next    = HOLD;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            HOLD: begin
                // Input side is stalled. out_data stays put until taken.
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Handshake outputs are a direct decode of the state flop.
    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == HOLD);
    assign out_data  = out_data_reg;

endmodule

// File: doc/bias_accumulator.md
# bias_accumulator

Accumulates a fixed-length window of signed partial products from the MAC array into one sum and adds the per-channel bias once per window. It emits one `BIAS_WIDTH` result per window over a valid/ready handshake. It sits directly upstream of `quantization`, which reduces each result to `DATA_WIDTH`. It also decouples the MAC stream from downstream stalls by holding the finished sum until it is taken.

## Interface
Parameters:
- `NUM_TERMS`, default 9: partial products per output window (3x3 kernel); legal range 2–255.
- `` `BIAS_WIDTH ``, `` `DATA_WIDTH ``: taken from `parameters.v`; not overridden locally.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  partial product present.
- `in_ready`  out  1  block accepts a partial product this cycle.
- `in_psum`  in  `BIAS_WIDTH`  signed two's-complement partial product.
- `bias`  in  `BIAS_WIDTH`  signed bias; sampled only with the first term of a window.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream (`quantization` path) takes result.
- `out_data`  out  `BIAS_WIDTH`  signed window result.

## Operation
- Transfer rules:
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- Internal registers:
  - Accumulator `acc` is signed, `BIAS_WIDTH + clog2(NUM_TERMS+1)` bits. No intermediate overflow is possible.
  - Term counter `cnt` is 0..`NUM_TERMS-1`.
- FSM states:
  - ACCUM: `in_ready=1`, `out_valid=0`.
  - HOLD: `in_ready=0`, `out_valid=1`.
- In ACCUM, on each input transfer:
  - If `cnt==0`: `acc <= sext(bias) + sext(in_psum)`.
  - Otherwise: `acc <= acc + sext(in_psum)`.
  - `cnt` increments.
- Window completion: on the transfer with `cnt==NUM_TERMS-1`:
  - `out_data <= fit(final sum)`.
  - `cnt <= 0`.
  - State goes to HOLD.
- `fit()` narrows the full-width sum to `BIAS_WIDTH` as defined under Configuration.
- Cycles with `in_valid=0` in ACCUM leave `acc` and `cnt` unchanged. Gaps are allowed anywhere in a window.
- In HOLD:
  - `out_data` is stable and `in_valid`/`in_psum` are ignored.
  - An output transfer returns the FSM to ACCUM.
- Reset values: state ACCUM, `cnt=0`, `acc=0`, `out_data=0`, `out_valid=0`, `in_ready=1`.
- Reset mid-window discards all accumulated terms. The next accepted term is treated as the first of a window, so bias is re-sampled.

## Timing
- All outputs are registered. `in_ready` and `out_valid` are decoded directly from state flops.
- Latency: last term accepted on edge N → `out_valid=1` and `out_data` valid after edge N.
- Output transfer on edge M → `out_valid=0`, `in_ready=1` after edge M. The first term of the next window can be accepted on edge M+1.
- Peak throughput: one result per `NUM_TERMS+1` cycles.
- `out_valid` never drops without an output transfer. `out_data` never changes while `out_valid=1`.
- `rst_n=0` on an edge overrides every other event on that edge, including a simultaneous output transfer.

## Configuration
- Macro: `BIAS_ACC_SAT_EN`.
- Defined: `fit()` saturates the sum to the signed `BIAS_WIDTH` range [−2^(BIAS_WIDTH−1), 2^(BIAS_WIDTH−1)−1].
- Undefined: `fit()` takes the low `BIAS_WIDTH` bits of the sum, i.e. two's-complement wrap.
- The macro has no effect on timing or handshake behaviour.

## Test plan
All scenarios use `BIAS_WIDTH=20`, `NUM_TERMS=9`.
1. Nine terms of 100 back-to-back, bias 50 → `out_valid` one cycle after ninth accept, `out_data=950`.
2. Nine terms of −1000 with random `in_valid` gaps, bias 0 → `out_data=−9000`. `cnt` is unaffected by idle cycles.
3. Nine terms of 300000, bias 0 → with `BIAS_ACC_SAT_EN`: `out_data=524287`. Without it: `out_data=−445728`. Repeat with −300000 → sat −524288; wrap 445728.
4. Result pending, `out_ready=0` for 5 cycles with `in_valid=1` and `in_psum=7` → `out_valid` held, `out_data` constant, `in_ready=0`, none of the offered terms absorbed. Then raise `out_ready` → transfer; `in_ready=1` next cycle.
5. Four terms of 50 (bias 10) accepted, then `rst_n=0` for one edge, then nine terms of 1 with bias 3 → `out_data=12`. All outputs read reset values during reset.
6. Bias changed on every cycle within a window (first-term bias 5, others 999), nine terms of 2 → `out_data=23`. This shows bias is sampled only with the first term.
